// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU result accumulator.
// Holds the default datapath width, the accumulate command encodings and the output-register state type.
package alu_pkg;

    localparam int ACC_W = 16;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_CLEAR = 3'b011
    } res_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/acc_arith.sv
// Combinational next-accumulator and carry/borrow computation.
// Define ALU_ACC_SAT_EN to clamp ADD to all-ones on carry and SUB to zero on borrow.
module acc_arith
    import alu_pkg::*;
#(
    parameter int N = ACC_W
) (
    input  logic [N-1:0] acc_i,
    input  logic [N-1:0] data_i,
    input  logic [2:0]   op_i,
    output logic [N-1:0] acc_next_o,
    output logic         carry_o
);

    // One extra bit so the MSB carries the add carry-out or the subtract borrow.
    logic [N:0] sum;
    logic [N:0] diff;

    assign sum  = {1'b0, acc_i} + {1'b0, data_i};
    assign diff = {1'b0, acc_i} - {1'b0, data_i};

    // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_next_o = acc_i;
        carry_o    = 1'b0;
        case (op_i)
            OP_LOAD:  acc_next_o = data_i;
            OP_ADD: begin
                acc_next_o = sum[N-1:0];
                carry_o    = sum[N];
`ifdef ALU_ACC_SAT_EN
                if (sum[N]) acc_next_o = '1;
`endif
            end
            OP_SUB: begin
                acc_next_o = diff[N-1:0];
                carry_o    = diff[N];
`ifdef ALU_ACC_SAT_EN
                if (diff[N]) acc_next_o = '0;
`endif
            end
            OP_CLEAR: acc_next_o = '0;
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator behind an ALU with a one-deep, full-throughput valid/ready output register.
// Define ALU_ACC_SAT_EN to build the saturating ADD/SUB variant of acc_arith.
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int N = ACC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         res_valid,
    output logic         res_ready,
    input  logic [N-1:0] res_data,
    input  logic [2:0]   res_op,
    input  logic         res_err,
    output logic [N-1:0] acc_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         flag_zero,
    output logic         flag_carry,
    output logic         flag_err,
    output logic [7:0]   op_count
);

    out_state_e  state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic         carry_q, carry_d;
    logic         err_q, err_d;
    logic [7:0]   cnt_q, cnt_d;

    logic [N-1:0] arith_acc;
    logic         arith_carry;
    logic         in_xfer;
    logic         out_xfer;

    acc_arith #(.N(N)) u_arith (
        .acc_i      (acc_q),
        .data_i     (res_data),
        .op_i       (res_op),
        .acc_next_o (arith_acc),
        .carry_o    (arith_carry)
    );

    // Ready depends only on registered state and out_ready, never on res_valid.
    assign out_valid = (state_q == FULL);
    assign res_ready = !out_valid || out_ready;
    assign in_xfer   = res_valid && res_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            EMPTY:   if (in_xfer) state_d = FULL;
            FULL:    if (out_xfer && !in_xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (in_xfer) begin
            cnt_d = cnt_q + 8'd1;
            if (res_err) begin
                // A faulty result never touches acc or carry, except that CLEAR still wipes acc and the error.
                if (res_op == OP_CLEAR) begin
                    acc_d = '0;
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                acc_d   = arith_acc;
                carry_d = arith_carry;
                if (res_op == OP_CLEAR) err_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign acc_val    = acc_q;
    assign out_data   = acc_q;
    assign flag_zero  = (acc_q == '0);
    assign flag_carry = carry_q;
    assign flag_err   = err_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator: reference model plus an output scoreboard.
// Honours ALU_ACC_SAT_EN so the same bench covers the wrapping and saturating builds.
module tb_alu_accumulator;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic        res_err;
    logic [15:0] acc_val;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_err;
    logic [7:0]  op_count;

    alu_accumulator #(.N(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_err    (res_err),
        .acc_val    (acc_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_err   (flag_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] acc_m;
    logic        carry_m;
    logic        err_m;
    logic [7:0]  cnt_m;
    logic        full_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic [2:0] op, input logic [15:0] d, input logic e);
        int s;
        cnt_m = cnt_m + 8'd1;
        if (e) begin
            if (op == 3'b011) begin
                acc_m = 16'h0000;
                err_m = 1'b0;
            end else begin
                err_m = 1'b1;
            end
        end else begin
            case (op)
                3'b000: begin acc_m = d; carry_m = 1'b0; end
                3'b001: begin
                    s       = int'(acc_m) + int'(d);
                    carry_m = (s > 65535);
                    acc_m   = 16'(s);
`ifdef ALU_ACC_SAT_EN
                    if (carry_m) acc_m = 16'hFFFF;
`endif
                end
                3'b010: begin
                    carry_m = (d > acc_m);
                    acc_m   = acc_m - d;
`ifdef ALU_ACC_SAT_EN
                    if (carry_m) acc_m = 16'h0000;
`endif
                end
                3'b011: begin acc_m = 16'h0000; carry_m = 1'b0; err_m = 1'b0; end
                default: carry_m = 1'b0;
            endcase
        end
    endtask

    // Called at a falling edge; applies one cycle of stimulus and returns at the next falling edge.
    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] d,
                         input logic e, input logic ordy);
        exp_t item;
        logic in_x;
        logic out_x;
        res_valid = v;
        res_op    = op;
        res_data  = d;
        res_err   = e;
        out_ready = ordy;
        #1;
        in_x  = v && (!full_m || ordy);
        out_x = full_m && ordy;
        check("res_ready", res_ready, !full_m || ordy);
        if (out_x) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                item = sb_q.pop_front();
                check("out_data", out_data, item.data);
                check("out_carry", flag_carry, item.carry);
                check("out_err", flag_err, item.err);
            end
        end
        if (in_x) begin
            model_step(op, d, e);
            item.data  = acc_m;
            item.carry = carry_m;
            item.err   = err_m;
            sb_q.push_back(item);
            full_m = 1'b1;
        end else if (out_x) begin
            full_m = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("acc_val", acc_val, acc_m);
        check("flag_zero", flag_zero, acc_m == 16'h0000);
        check("flag_carry", flag_carry, carry_m);
        check("flag_err", flag_err, err_m);
        check("op_count", op_count, cnt_m);
        check("out_valid", out_valid, full_m);
    endtask

    task automatic drain();
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        res_valid = 1'b1;
        res_op    = 3'b000;
        res_data  = 16'hABCD;
        res_err   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        res_valid = 1'b0;
        out_ready = 1'b0;
        acc_m     = 16'h0000;
        carry_m   = 1'b0;
        err_m     = 1'b0;
        cnt_m     = 8'd0;
        full_m    = 1'b0;
        sb_q.delete();
        #1;
        check("rst_acc", acc_val, 16'h0000);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_zero", flag_zero, 1'b1);
        check("rst_carry", flag_carry, 1'b0);
        check("rst_err", flag_err, 1'b0);
        check("rst_count", op_count, 8'd0);
        check("rst_ready", res_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        res_valid = 1'b0;
        res_op    = 3'b000;
        res_data  = 16'h0000;
        res_err   = 1'b0;
        out_ready = 1'b0;
        do_reset();
        @(negedge clk);

        // Basic load then add.
        drive(1'b1, 3'b000, 16'h00FF, 1'b0, 1'b1);
        check("ld_acc", acc_val, 16'h00FF);
        drive(1'b1, 3'b001, 16'h0001, 1'b0, 1'b1);
        check("add_acc", acc_val, 16'h0100);
        check("add_carry", flag_carry, 1'b0);
        check("add_count", op_count, 8'd2);
        drain();

        // Carry out of ADD.
        drive(1'b1, 3'b000, 16'hFFFF, 1'b0, 1'b1);
        drive(1'b1, 3'b001, 16'h0002, 1'b0, 1'b1);
        check("ovf_carry", flag_carry, 1'b1);
`ifdef ALU_ACC_SAT_EN
        check("ovf_acc", acc_val, 16'hFFFF);
`else
        check("ovf_acc", acc_val, 16'h0001);
`endif
        drain();

        // Borrow out of SUB.
        drive(1'b1, 3'b000, 16'h0003, 1'b0, 1'b1);
        drive(1'b1, 3'b010, 16'h0005, 1'b0, 1'b1);
        check("brw_carry", flag_carry, 1'b1);
`ifdef ALU_ACC_SAT_EN
        check("brw_acc", acc_val, 16'h0000);
        check("brw_zero", flag_zero, 1'b1);
`else
        check("brw_acc", acc_val, 16'hFFFE);
        check("brw_zero", flag_zero, 1'b0);
`endif
        drain();

        // Downstream stall with a pending command, then back-to-back resume.
        drive(1'b1, 3'b000, 16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b001, 16'h0001, 1'b0, 1'b0);
            check("stall_data", out_data, 16'h1234);
            check("stall_ready", res_ready, 1'b0);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 3'b001, 16'h0001, 1'b0, 1'b1);
        check("resume_acc", acc_val, 16'h1237);
        drain();

        // Sticky error cleared only by CLEAR.
        drive(1'b1, 3'b000, 16'h0010, 1'b0, 1'b1);
        drive(1'b1, 3'b001, 16'h0005, 1'b1, 1'b1);
        check("err_acc", acc_val, 16'h0010);
        check("err_set", flag_err, 1'b1);
        drive(1'b1, 3'b001, 16'h0001, 1'b0, 1'b1);
        drive(1'b1, 3'b001, 16'h0001, 1'b0, 1'b1);
        check("err_sticky", flag_err, 1'b1);
        drive(1'b1, 3'b011, 16'h7777, 1'b0, 1'b1);
        check("clr_acc", acc_val, 16'h0000);
        check("clr_err", flag_err, 1'b0);
        drain();

        // Random traffic with random backpressure and occasional errors.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset while FULL with a valid command pending.
        drive(1'b1, 3'b000, 16'h5555, 1'b0, 1'b0);
        check("pre_rst_full", out_valid, 1'b1);
        do_reset();
        @(negedge clk);

        // op_count wraps after 256 accepted NOPs.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 3'(4 + (i % 4)), 16'($urandom), 1'b0, 1'b1);
            if (i == 254) check("cnt_255", op_count, 8'd255);
        end
        check("cnt_wrap", op_count, 8'd0);
        drain();
        check("sb_leftover", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
